// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Owns the single register-file write port behind the writeback stage. Two
// writers share it:
//   - ALU results: in-order and stallable. If one loses the port it is queued
//     in a small in-order FIFO and drained when the port is free.
//   - LSU load returns: these arrive late and have priority over the ALU.
// A starvation counter forces the FIFO head onto the port after STARVE_MAX
// consecutive LSU wins, so queued ALU results always make progress.
//
// Winner each cycle, in priority order:
//   forced drain > LSU > FIFO head > ALU bypass > none
//
// Optional feature macro: WB_ALU_BYPASS_EN
//   defined   : an ALU result with the FIFO empty and no LSU goes straight to
//               the port (1-cycle latency).
//   undefined : every accepted ALU result is pushed first (2-cycle minimum).
//
// Parameters
//   BUF_DEPTH   ALU pending-FIFO entries (power of 2, >= 2)
//   STARVE_MAX  LSU wins, with the FIFO non-empty, before a forced drain
//
// Ports
//   clk_i        clock, rising edge
//   rstn_i       synchronous reset, active low
//   alu_valid_i  ALU result offered
//   alu_rd_i     ALU destination register
//   alu_data_i   ALU result data
//   alu_ready_o  ALU may hand over a result (FIFO not full)
//   lsu_valid_i  load data offered
//   lsu_rd_i     load destination register
//   lsu_data_i   load data
//   lsu_ready_o  load accepted (low only in a forced-drain cycle)
//   rf_we_o      register-file write enable (registered)
//   rf_waddr_o   register-file write address (registered)
//   rf_wdata_o   register-file write data (registered)
//   pending_o    FIFO non-empty
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
   parameter int BUF_DEPTH  = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        alu_valid_i,
   input  logic [4:0]  alu_rd_i,
   input  logic [31:0] alu_data_i,
   output logic        alu_ready_o,
   input  logic        lsu_valid_i,
   input  logic [4:0]  lsu_rd_i,
   input  logic [31:0] lsu_data_i,
   output logic        lsu_ready_o,
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   output logic        pending_o
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ST_W  = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_e;

   state_e            state_q, state_d;
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ST_W-1:0]   starve_q, starve_d;
   logic [4:0]        buf_rd_q   [BUF_DEPTH];
   logic [31:0]       buf_data_q [BUF_DEPTH];

   logic        fifo_empty, forced, alu_acc;
   logic        win, pop, push, lsu_win, alu_win;
   logic [4:0]  win_rd;
   logic [31:0] win_data;

   function automatic state_e occupancy(input logic [CNT_W-1:0] cnt);
      if (cnt == '0)
         return EMPTY;
      else if (cnt == CNT_W'(BUF_DEPTH))
         return FULL;
      else
         return PARTIAL;
   endfunction

   assign fifo_empty  = (count_q == '0);
   assign forced      = (starve_q == ST_W'(STARVE_MAX)) && !fifo_empty;
   // Ready depends on registered state only, never on alu_valid_i.
   assign alu_ready_o = (state_q != FULL);
   assign lsu_ready_o = !forced;
   assign pending_o   = (state_q != EMPTY);
   assign alu_acc     = alu_valid_i && alu_ready_o;

   always_comb begin
      win      = 1'b0;
      pop      = 1'b0;
      lsu_win  = 1'b0;
      alu_win  = 1'b0;
      win_rd   = buf_rd_q[rd_ptr_q];
      win_data = buf_data_q[rd_ptr_q];
      if (forced) begin
         win = 1'b1;
         pop = 1'b1;
      end else if (lsu_valid_i) begin
         win      = 1'b1;
         lsu_win  = 1'b1;
         win_rd   = lsu_rd_i;
         win_data = lsu_data_i;
      end else if (!fifo_empty) begin
         win = 1'b1;
         pop = 1'b1;
`ifdef WB_ALU_BYPASS_EN
      end else if (alu_valid_i) begin
         win      = 1'b1;
         alu_win  = 1'b1;
         win_rd   = alu_rd_i;
         win_data = alu_data_i;
`endif
      end
   end

   // An accepted ALU result that did not take the port goes to the FIFO tail.
   assign push = alu_acc && !alu_win;

   always_comb begin
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      state_d = occupancy(count_d);

      starve_d = starve_q;
      if (pop || fifo_empty)
         starve_d = '0;
      else if (lsu_win && (starve_q != ST_W'(STARVE_MAX)))
         starve_d = starve_q + ST_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q    <= EMPTY;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         starve_q   <= '0;
         rf_we_o    <= 1'b0;
         rf_waddr_o <= '0;
         rf_wdata_o <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         if (pop)
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push)
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         // x0 winners are consumed but never written; address/data still
         // follow the winner, and hold when there is no winner.
         rf_we_o <= win && (win_rd != 5'd0);
         if (win) begin
            rf_waddr_o <= win_rd;
            rf_wdata_o <= win_data;
         end
      end
   end

   // FIFO storage carries data only; occupancy lives in the control state.
   always_ff @(posedge clk_i) begin
      if (push) begin
         buf_rd_q[wr_ptr_q]   <= alu_rd_i;
         buf_data_q[wr_ptr_q] <= alu_data_i;
      end
   end

endmodule
